stream_mux: RTL and testbench
=============================

# stream_mux

Parametrised N-channel streaming multiplexer with round-robin arbitration and a registered valid/ready output stage. It is the next generation of the team's combinational 4:1 mux: instead of a static select input, the block picks among requesting channels fairly, carries WIDTH-bit data per channel, and tags each output beat with its source channel. It sits between several producer streams and one shared downstream consumer.

## Interface
Parameters:
- N_CH, 4, number of input channels (2..16)
- WIDTH, 8, data bits per beat
- CH_W, $clog2(N_CH), width of channel tag (derived; do not override)

Ports:
- clk  input  1  single clock; all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_data  input  N_CH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- in_valid  input  N_CH  per-channel beat valid
- in_ready  output  N_CH  per-channel accept; at most one bit high per cycle
- in_last  input  N_CH  end-of-packet marker (only with STREAM_MUX_LOCK_EN)
- out_data  output  WIDTH  registered data
- out_valid  output  1  registered beat valid
- out_ready  input  1  downstream accept
- out_ch  output  CH_W  source channel of current out beat
- out_last  output  1  registered copy of in_last (only with STREAM_MUX_LOCK_EN)

## Operation
- Transfer on input k: in_valid[k] && in_ready[k]. Transfer on output: out_valid && out_ready.
- load_en = !out_valid || out_ready. in_ready is all-zero when load_en is 0.
- When load_en is 1 and any in_valid is set: grant = first requesting channel scanning ptr+1, ptr+2, … modulo N_CH. in_ready = one-hot(grant). in_ready may depend combinationally on in_valid and out_ready; in_valid must not depend on in_ready.
- On a grant: out_data <= granted data, out_ch <= grant, out_valid <= 1, ptr <= grant.
- When load_en is 1 and no in_valid: out_valid <= 0; out_data and out_ch hold their values.
- When load_en is 0: all output registers and ptr hold.
- Fairness: a channel that keeps in_valid high is granted within N_CH output transfers.
- Data values are passed through unmodified. Only one stage exists, so no width arithmetic beyond the pointer wrap N_CH-1 -> 0.

## Timing
- Reset values: out_valid=0, out_data=0, out_ch=0, out_last=0, ptr=N_CH-1, so channel 0 has priority first. Lock state is IDLE.
- Reset mid-stream drops the held beat. in_ready is 0 during any cycle with rst=1.
- Latency: an input transfer in cycle t produces out_valid in cycle t+1.
- Throughput: 1 beat/cycle while out_ready is held high.
- Backpressure: with out_valid=1 and out_ready=0, out_data, out_ch and out_last stay stable and in_ready stays all-zero.
- Simultaneous output drain and input grant in the same cycle: the new beat replaces the old one with no bubble.

## Configuration
- STREAM_MUX_LOCK_EN defined:
  - in_last and out_last ports exist.
  - Two-state FSM: IDLE and LOCKED(ch).
  - IDLE: normal round-robin. A granted transfer with in_last=0 moves to LOCKED(grant).
  - LOCKED(ch): only channel ch can be granted; other channels see in_ready=0 even if ch is idle. A transfer of ch with in_last=1 returns to IDLE, and ptr updates as usual.
  - A single-beat packet (in_last=1 on first beat) stays in IDLE.
- STREAM_MUX_LOCK_EN undefined:
  - No in_last or out_last ports and no FSM.
  - Every beat is arbitrated independently.

## Structure
- Package stream_mux_pkg holds:
  - the lock-state enum (IDLE, LOCKED)
  - the ch_w(n) function returning max(1, $clog2(n))
- Sub-module rr_arbiter(N_CH):
  - inputs req, ptr, en, optional mask
  - outputs one-hot grant and encoded grant index
  - purely combinational; ptr register lives in stream_mux

## Test plan
Bench parameters: N_CH=4, WIDTH=8.
- Reset: assert rst 2 cycles with all in_valid=1 -> in_ready=0000, out_valid=0, out_data=0x00, out_ch=0 throughout.
- Single channel: in_valid=0100, data ch2=0xA5, out_ready=1 -> in_ready=0100 in the same cycle; next cycle out_valid=1, out_data=0xA5, out_ch=2.
- Round-robin: all channels valid continuously with data 0x10/0x11/0x12/0x13, out_ready=1 -> out_ch sequence 0,1,2,3,0 with matching data, one beat per cycle.
- Backpressure: out_ready=0 for 3 cycles with a beat (out_data=0x11, out_ch=1) held -> outputs stable and in_ready=0000; on release the next beat comes from ch2 with no bubble.
- Wrap and skip: ptr=3, in_valid=0010 -> grant ch1; then in_valid=1001 -> grant ch3 before ch0.
- Lock (with STREAM_MUX_LOCK_EN): ch0 sends 3 beats with in_last on beat 3 while ch1 stays valid -> out_ch=0,0,0 then 1; out_last=1 only on the third ch0 beat.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg: lock-state enum and channel-tag width helper shared by stream_mux and rr_arbiter
package stream_mux_pkg;

    typedef enum logic {IDLE, LOCKED} lock_state_e;

    function automatic int ch_w(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, scanning from ptr+1 upward modulo N_CH
module rr_arbiter #(
    parameter int N_CH = 4,
    parameter int CH_W = 2
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    input  logic            en,
    input  logic [N_CH-1:0] mask,
    output logic [N_CH-1:0] grant,
    output logic [CH_W-1:0] grant_idx
);

    logic found;
    int   c;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        c         = 0;
        for (int i = 1; i <= N_CH; i++) begin
            c = (int'(ptr) + i) % N_CH;
            if (en && !found && req[c] && mask[c]) begin
                grant[c]  = 1'b1;
                grant_idx = CH_W'(c);
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux.sv
// stream_mux: N-channel round-robin stream mux with registered output stage; STREAM_MUX_LOCK_EN adds packet locking on in_last
module stream_mux
    import stream_mux_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8,
    parameter int CH_W  = ch_w(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
`ifdef STREAM_MUX_LOCK_EN
    input  logic [N_CH-1:0]       in_last,
    output logic                  out_last,
`endif
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CH_W-1:0]       out_ch
);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [CH_W-1:0]  out_ch_q, out_ch_d;
    logic [CH_W-1:0]  ptr_q, ptr_d;
    logic [N_CH-1:0]  grant, mask;
    logic [CH_W-1:0]  grant_idx;
    logic             load_en, any_grant;

    assign load_en   = !out_valid_q || out_ready;
    assign any_grant = |grant;
    assign in_ready  = grant;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;

`ifdef STREAM_MUX_LOCK_EN
    lock_state_e state_q, state_d;
    logic        out_last_q, out_last_d;
    // while locked, the owner is always the last granted channel, i.e. ptr
    assign mask     = (state_q == LOCKED) ? (N_CH'(1) << ptr_q) : '1;
    assign out_last = out_last_q;
`else
    assign mask = '1;
`endif

    rr_arbiter #(.N_CH(N_CH), .CH_W(CH_W)) u_arb (
        .req      (in_valid),
        .ptr      (ptr_q),
        .en       (load_en && !rst),
        .mask     (mask),
        .grant    (grant),
        .grant_idx(grant_idx)
    );

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = load_en ? any_grant : out_valid_q;
        out_ch_d    = any_grant ? grant_idx : out_ch_q;
        ptr_d       = any_grant ? grant_idx : ptr_q;
        if (any_grant) out_data_d = in_data[int'(grant_idx)*WIDTH +: WIDTH];
`ifdef STREAM_MUX_LOCK_EN
        out_last_d = any_grant ? in_last[grant_idx] : out_last_q;
        state_d    = any_grant ? (in_last[grant_idx] ? IDLE : LOCKED) : state_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            ptr_q       <= CH_W'(N_CH-1);
`ifdef STREAM_MUX_LOCK_EN
            out_last_q  <= 1'b0;
            state_q     <= IDLE;
`endif
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
`ifdef STREAM_MUX_LOCK_EN
            out_last_q  <= out_last_d;
            state_q     <= state_d;
`endif
        end
    end

endmodule

// File: tb/tb_stream_mux.sv
// tb_stream_mux: directed vectors for stream_mux (N_CH=4, WIDTH=8) checked against a behavioural model every cycle
module tb_stream_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_ch;
`ifdef STREAM_MUX_LOCK_EN
    logic [3:0]  in_last;
    logic        out_last;
`endif

    int vectors = 0;
    int errs    = 0;

    stream_mux #(.N_CH(4), .WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
`ifdef STREAM_MUX_LOCK_EN
        .in_last  (in_last),
        .out_last (out_last),
`endif
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ch   (out_ch)
    );

    always #5 clk = ~clk;

    int m_ptr = 3, m_data = 0, m_ch = 0, m_last = 0;
    bit m_valid = 0, m_locked = 0;

    // which channel the spec's rules pick this cycle, -1 for none
    function automatic int exp_grant();
        if (rst || (m_valid && !out_ready)) return -1;
        for (int i = 1; i <= 4; i++) begin
            int c;
            c = (m_ptr + i) % 4;
            if (in_valid[c] && (!m_locked || c == m_ptr)) return c;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        int g;
        if (rst) begin
            m_ptr = 3; m_valid = 0; m_data = 0; m_ch = 0; m_last = 0; m_locked = 0;
        end else begin
            g = exp_grant();
            if (g >= 0) begin
                m_valid = 1;
                m_data  = int'(in_data[g*8 +: 8]);
                m_ch    = g;
                m_ptr   = g;
`ifdef STREAM_MUX_LOCK_EN
                m_last   = int'(in_last[g]);
                m_locked = !in_last[g];
`endif
            end else if (!m_valid || out_ready) begin
                m_valid = 0;
            end
        end
    end

    task automatic cmp(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        int g;
        g = exp_grant();
        cmp("model in_ready", int'(in_ready), (g < 0) ? 0 : (1 << g));
        cmp("model out_valid", int'(out_valid), int'(m_valid));
        cmp("model out_data", int'(out_data), m_data);
        cmp("model out_ch", int'(out_ch), m_ch);
`ifdef STREAM_MUX_LOCK_EN
        cmp("model out_last", int'(out_last), m_last);
`endif
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1; in_valid = 4'hF; out_ready = 1; in_data = 32'h13121110;
`ifdef STREAM_MUX_LOCK_EN
        in_last = 4'hF;
`endif
        cyc();
        for (int k = 0; k < 2; k++) begin
            at_neg();
            cmp("reset in_ready", int'(in_ready), 0);
            cmp("reset out_valid", int'(out_valid), 0);
            cmp("reset out_data", int'(out_data), 0);
            cmp("reset out_ch", int'(out_ch), 0);
            cyc();
        end
        rst = 0; in_valid = 4'b0100; in_data = 32'h00A50000;
        at_neg();
        cmp("single in_ready", int'(in_ready), 4'b0100);
        cyc();
        in_valid = 0;
        at_neg();
        cmp("single out_valid", int'(out_valid), 1);
        cmp("single out_data", int'(out_data), 8'hA5);
        cmp("single out_ch", int'(out_ch), 2);
        cyc();
        rst = 1;
        cyc();
        rst = 0; in_valid = 4'hF; in_data = 32'h13121110;
        for (int k = 0; k < 5; k++) begin
            cyc();
            at_neg();
            cmp("rr out_ch", int'(out_ch), k % 4);
            cmp("rr out_data", int'(out_data), 8'h10 + k % 4);
            cmp("rr out_valid", int'(out_valid), 1);
        end
        cyc();
        out_ready = 0;
        for (int k = 0; k < 3; k++) begin
            at_neg();
            cmp("bp in_ready", int'(in_ready), 0);
            cmp("bp out_data", int'(out_data), 8'h11);
            cmp("bp out_ch", int'(out_ch), 1);
            cmp("bp out_valid", int'(out_valid), 1);
            cyc();
        end
        out_ready = 1;
        at_neg();
        cmp("release in_ready", int'(in_ready), 4'b0100);
        cyc();
        in_valid = 4'b1000;
        at_neg();
        cmp("release out_ch", int'(out_ch), 2);
        cmp("release out_valid", int'(out_valid), 1);
        cyc();
        in_valid = 4'b0010;
        at_neg();
        cmp("wrap in_ready", int'(in_ready), 4'b0010);
        cyc();
        in_valid = 4'b1001;
        at_neg();
        cmp("skip in_ready", int'(in_ready), 4'b1000);
        cyc();
        in_valid = 0;
        at_neg();
        cmp("skip out_ch", int'(out_ch), 3);
        cmp("skip out_data", int'(out_data), 8'h13);
        cyc();
        cyc();
`ifdef STREAM_MUX_LOCK_EN
        rst = 1;
        cyc();
        rst = 0; in_valid = 4'b0011;
        for (int b = 0; b < 4; b++) begin
            in_last = (b == 2) ? 4'b0011 : 4'b0010;
            cyc();
            at_neg();
            cmp("lock out_ch", int'(out_ch), (b < 3) ? 0 : 1);
            if (b < 3) cmp("lock out_last", int'(out_last), (b == 2) ? 1 : 0);
        end
        in_valid = 0;
        cyc();
        cyc();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
